// File: rtl/ufm_cmd_arbiter_if.sv
// Requester/engine signal bundle for the UFM command arbiter.
// Latency: none (wires only).
// Backpressure: none here; requesters hold req until done, the engine paces via BUSY.
//
// Ports carried:
//   req_i/req_cmd_i/req_page_i : level requests with per-requester cmd/page fields
//   gnt_o/done_o/err_o         : one-hot grant, completion pulse, error flag
//   cmd/ufm_page/GO/BUSY/ERR   : UFM engine command interface
//   arb_busy_o/hang_o          : arbiter activity and sticky timeout flag
// modport master = arbiter side, modport slave = requesters + engine side.
interface ufm_cmd_arbiter_if;
  logic [2:0]  req_i;
  logic [8:0]  req_cmd_i;
  logic [32:0] req_page_i;
  logic [2:0]  gnt_o;
  logic [2:0]  done_o;
  logic [2:0]  err_o;
  logic [2:0]  cmd;
  logic [10:0] ufm_page;
  logic        GO;
  logic        BUSY;
  logic        ERR;
  logic        arb_busy_o;
  logic        hang_o;

  modport master (
    input  req_i, req_cmd_i, req_page_i, BUSY, ERR,
    output gnt_o, done_o, err_o, cmd, ufm_page, GO, arb_busy_o, hang_o
  );

  modport slave (
    output req_i, req_cmd_i, req_page_i, BUSY, ERR,
    input  gnt_o, done_o, err_o, cmd, ufm_page, GO, arb_busy_o, hang_o
  );
endinterface

// File: rtl/ufm_cmd_arbiter.sv
// Shares the UFM command interface between erase (req0), event-save (req1) and page-read (req2).
// Latency: gnt_o 1 cycle after a request is seen in IDLE, GO 2 cycles after gnt_o.
// Backpressure: requests wait while the arbiter is busy or the engine BUSY is high; held requests are never lost.
//
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   bus (master)   : requester handshake and UFM engine command signals
module ufm_cmd_arbiter #(
  parameter logic [10:0] PAGE_MAX    = 11'd2046,
  parameter int unsigned ACK_TO      = 64,
  parameter int unsigned TIMEOUT_CYC = 2418000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  ufm_cmd_arbiter_if.master  bus
);

  localparam logic [21:0] ACK_LAST = 22'(ACK_TO - 1);
  localparam logic [21:0] TO_LAST  = 22'(TIMEOUT_CYC - 1);

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_ERASE = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  gnt_q;
  logic [2:0]  cmd_q;
  logic [10:0] page_q;
  logic        err_q;
  logic        hang_q;
  logic        prefer1_q;   // 1: req1 wins the next req1/req2 tie
  logic        contest_q;   // current grant came from a req1/req2 tie-break
  logic [21:0] cnt_q;

  logic [2:0]  win;
  logic [2:0]  win_cmd;
  logic [10:0] win_page;
  logic        start;
  logic        err_ld;
  logic        err_val;
  logic        set_hang;
  logic        cmd_rw;
  logic        reject;

  // Fixed priority for req0, round-robin tie-break between req1 and req2.
  always_comb begin
    win = 3'b000;
    if (bus.req_i[0]) begin
      win = 3'b001;
    end else if (bus.req_i[1] && bus.req_i[2]) begin
      win = prefer1_q ? 3'b010 : 3'b100;
    end else if (bus.req_i[1]) begin
      win = 3'b010;
    end else if (bus.req_i[2]) begin
      win = 3'b100;
    end
  end

  always_comb begin
    win_cmd  = 3'b000;
    win_page = 11'd0;
    if (win[0]) begin
      win_cmd  = bus.req_cmd_i[2:0];
      win_page = bus.req_page_i[10:0];
    end else if (win[1]) begin
      win_cmd  = bus.req_cmd_i[5:3];
      win_page = bus.req_page_i[21:11];
    end else if (win[2]) begin
      win_cmd  = bus.req_cmd_i[8:6];
      win_page = bus.req_page_i[32:22];
    end
  end

  // Erase ignores the page field, so only read/write are range checked.
  assign cmd_rw = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
  assign reject = !(cmd_rw || (cmd_q == CMD_ERASE)) || (cmd_rw && (page_q > PAGE_MAX));

  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    err_ld         = 1'b0;
    err_val        = 1'b0;
    set_hang       = 1'b0;
    bus.GO         = 1'b0;
    bus.done_o     = 3'b000;
    bus.err_o      = 3'b000;
    bus.arb_busy_o = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // Holding off on BUSY keeps us from talking to an engine that is
        // still finishing (or stuck in) a command from before a reset/timeout.
        if (!bus.BUSY && (bus.req_i != 3'b000)) begin
          state_d = S_ARB;
          start   = 1'b1;
        end
      end
      S_ARB: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (reject) begin
          state_d = S_COMPLETE;
          err_ld  = 1'b1;
          err_val = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.GO = 1'b1;
        if (bus.BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          state_d  = S_COMPLETE;
          err_ld   = 1'b1;
          err_val  = 1'b1;
          set_hang = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.BUSY) begin
          state_d = S_COMPLETE;
          err_ld  = 1'b1;
          err_val = bus.ERR;
        end else if (cnt_q == TO_LAST) begin
          state_d  = S_COMPLETE;
          err_ld   = 1'b1;
          err_val  = 1'b1;
          set_hang = 1'b1;
        end
      end
      S_COMPLETE: begin
        bus.done_o = gnt_q;
        bus.err_o  = gnt_q & {3{err_q}};
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= 3'b000;
      cmd_q     <= 3'b000;
      page_q    <= 11'd0;
      err_q     <= 1'b0;
      hang_q    <= 1'b0;
      prefer1_q <= 1'b1;
      contest_q <= 1'b0;
      cnt_q     <= 22'd0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every state entry so each timeout is an exact count.
      cnt_q   <= (state_d != state_q) ? 22'd0 : cnt_q + 22'd1;
      if (start) begin
        gnt_q     <= win;
        cmd_q     <= win_cmd;
        page_q    <= win_page;
        err_q     <= 1'b0;
        contest_q <= !bus.req_i[0] && bus.req_i[1] && bus.req_i[2];
      end
      if (err_ld) begin
        err_q <= err_val;
      end
      if (set_hang) begin
        hang_q <= 1'b1;
      end
      if (state_q == S_COMPLETE) begin
        gnt_q  <= 3'b000;
        cmd_q  <= 3'b000;
        page_q <= 11'd0;
        err_q  <= 1'b0;
        // The turn only passes when the tie-break was actually used, so a
        // lone req1 or req2 does not consume the other's next turn.
        if (contest_q) begin
          prefer1_q <= gnt_q[2];
        end
      end
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.cmd      = cmd_q;
  assign bus.ufm_page = page_q;
  assign bus.hang_o   = hang_q;

endmodule

// File: tb/tb_ufm_cmd_arbiter.sv
// Directed bench for ufm_cmd_arbiter with a behavioural UFM engine.
// Latency: n/a.
// Backpressure: engine model delays BUSY and holds it for programmable lengths.
module tb_ufm_cmd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ufm_cmd_arbiter_if bus();

  ufm_cmd_arbiter #(.TIMEOUT_CYC(300)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Engine model controls
  int   eng_delay  = 0;
  int   eng_len    = 3;
  logic eng_err    = 1'b0;
  logic eng_mute   = 1'b0;
  logic eng_force  = 1'b0;
  logic force_busy = 1'b0;

  typedef struct {
    int          r;
    logic [2:0]  c;
    logic [10:0] p;
    int          dly;
    int          len;
    logic        ein;
    logic        exp_go;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   served[3];
  int   onehot_bad = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input int r);
    return 3'(1 << r);
  endfunction

  task automatic set_req(input int r, input logic [2:0] c, input logic [10:0] p);
    bus.req_cmd_i[3*r +: 3]   = c;
    bus.req_page_i[11*r +: 11] = p;
    bus.req_i[r]              = 1'b1;
  endtask

  // Engine: answers GO after eng_delay cycles, holds BUSY eng_len cycles,
  // presents ERR in the cycle BUSY falls.
  initial begin
    int eng_cnt;
    int eng_phase;
    bus.BUSY  = 1'b0;
    bus.ERR   = 1'b0;
    eng_phase = 0;
    eng_cnt   = 0;
    forever begin
      @(negedge clk);
      if (eng_force) begin
        bus.BUSY  = force_busy;
        bus.ERR   = 1'b0;
        eng_phase = 0;
      end else begin
        case (eng_phase)
          0: begin
            bus.BUSY = 1'b0;
            bus.ERR  = 1'b0;
            if (bus.GO && !eng_mute) begin
              if (eng_delay == 0) begin
                bus.BUSY  = 1'b1;
                eng_cnt   = eng_len;
                eng_phase = 2;
              end else begin
                eng_cnt   = eng_delay;
                eng_phase = 1;
              end
            end
          end
          1: begin
            eng_cnt--;
            if (eng_cnt == 0) begin
              bus.BUSY  = 1'b1;
              eng_cnt   = eng_len;
              eng_phase = 2;
            end
          end
          2: begin
            eng_cnt--;
            if (eng_cnt == 0) begin
              bus.BUSY  = 1'b0;
              bus.ERR   = eng_err;
              eng_phase = 3;
            end
          end
          default: begin
            bus.ERR   = 1'b0;
            eng_phase = 0;
          end
        endcase
      end
    end
  end

  // Runs one request to completion. Latencies are counted in cycles from the grant.
  task automatic run_txn(input int r, input logic [2:0] c, input logic [10:0] p,
                         output logic [2:0] g, output logic [2:0] dn, output logic [2:0] er,
                         output int go_cyc, output int done_lat);
    int   k;
    int   go_lat;
    logic stable_ok;
    g = 3'b000; dn = 3'b000; er = 3'b000;
    go_cyc = 0; done_lat = -1; go_lat = -1; stable_ok = 1'b1;
    set_req(r, c, p);
    k = 0;
    while (bus.gnt_o == 3'b000 && k < 1000) begin
      tick();
      k++;
    end
    check("grant_seen", 32'(k < 1000), 1);
    g = bus.gnt_o;
    check("cmd_at_grant", bus.cmd, c);
    check("page_at_grant", bus.ufm_page, p);
    check("arb_busy_at_grant", bus.arb_busy_o, 1);
    k = 0;
    while (bus.done_o == 3'b000 && k < 2000) begin
      if (bus.GO) begin
        if (go_lat < 0) go_lat = k;
        go_cyc++;
        if (bus.cmd !== c || bus.ufm_page !== p) stable_ok = 1'b0;
      end
      tick();
      k++;
    end
    check("done_seen", 32'(k < 2000), 1);
    done_lat = k;
    dn = bus.done_o;
    er = bus.err_o;
    check("cmd_held_in_complete", bus.cmd, c);
    check("go_fields_stable", stable_ok, 1);
    if (go_cyc > 0) check("go_latency", go_lat, 2);
    bus.req_i[r] = 1'b0;
    tick();
    check("gnt_dropped", bus.gnt_o, 0);
    check("done_single", bus.done_o, 0);
    check("cmd_cleared", {bus.cmd, bus.ufm_page}, 0);
  endtask

  task automatic holdoff_then_grant(input int r);
    int grants = 0;
    int k = 0;
    while (bus.BUSY && k < 1000) begin
      if (bus.gnt_o != 3'b000) grants++;
      tick();
      k++;
    end
    check("holdoff_bounded", 32'(k < 1000), 1);
    check("holdoff_no_grant", grants, 0);
    check("gnt_at_busy_fall", bus.gnt_o, 0);
    tick();
    check("gnt_after_busy_fall", bus.gnt_o, onehot(r));
  endtask

  task automatic wait_done(input int r, input logic exp_err);
    int k = 0;
    while (bus.done_o == 3'b000 && k < 2000) begin
      tick();
      k++;
    end
    check("wait_done_seen", 32'(k < 2000), 1);
    check("wait_done_who", bus.done_o, onehot(r));
    check("wait_done_err", bus.err_o, exp_err ? onehot(r) : 3'b000);
    bus.req_i[r] = 1'b0;
    tick();
  endtask

  task automatic collect(input int n);
    int got = 0;
    int k = 0;
    while (got < n && k < 2000) begin
      tick();
      k++;
      if ($countones(bus.gnt_o) > 1 || $countones(bus.done_o) > 1) onehot_bad++;
      if (bus.GO && $countones(bus.gnt_o) != 1) onehot_bad++;
      if (bus.done_o != 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (bus.done_o[i]) begin
            served[got] = i;
            bus.req_i[i] = 1'b0;
          end
        end
        got++;
      end
    end
    check("collect_count", got, n);
  endtask

  initial begin
    logic [2:0] g, dn, er;
    int go_cyc, done_lat;
    int grants;
    int k;

    rst            = 1'b1;
    bus.req_i      = 3'b000;
    bus.req_cmd_i  = 9'd0;
    bus.req_page_i = 33'd0;

    //            r  cmd     page        dly len ein go err
    vecs[0] = '{1, 3'b010, 11'd5,     3, 100, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2, 3'b001, 11'd2047,  0,   0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1, 3'b111, 11'd5,     0,   0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 3'b011, 11'd2047,  1,  10, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2, 3'b001, 11'd2046,  0,   5, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1, 3'b010, 11'd2047,  0,   0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{0, 3'b000, 11'd0,     0,   0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2, 3'b100, 11'd1,     0,   0, 1'b0, 1'b0, 1'b1};

    tick();
    tick();
    check("rst_gnt", bus.gnt_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_page", bus.ufm_page, 0);
    check("rst_go", bus.GO, 0);
    check("rst_arb_busy", bus.arb_busy_o, 0);
    check("rst_hang", bus.hang_o, 0);
    rst = 1'b0;
    tick();

    // Single-requester vectors
    for (int i = 0; i < 8; i++) begin
      eng_delay = vecs[i].dly;
      eng_len   = vecs[i].len;
      eng_err   = vecs[i].ein;
      run_txn(vecs[i].r, vecs[i].c, vecs[i].p, g, dn, er, go_cyc, done_lat);
      check("vec_gnt", g, onehot(vecs[i].r));
      check("vec_done", dn, onehot(vecs[i].r));
      check("vec_err", er, vecs[i].exp_err ? onehot(vecs[i].r) : 3'b000);
      check("vec_go_cycles", go_cyc, vecs[i].exp_go ? vecs[i].dly + 1 : 0);
      check("vec_done_latency", done_lat,
            vecs[i].exp_go ? vecs[i].dly + vecs[i].len + 3 : 2);
      tick();
    end
    check("no_hang_after_vectors", bus.hang_o, 0);

    // Priority and round-robin: all three at once, then req1+req2 again
    eng_delay      = 0;
    eng_len        = 3;
    eng_err        = 1'b0;
    bus.req_cmd_i  = {3'b001, 3'b001, 3'b011};
    bus.req_page_i = {11'd2, 11'd1, 11'd0};
    bus.req_i      = 3'b111;
    collect(3);
    check("rr1_first", served[0], 0);
    check("rr1_second", served[1], 1);
    check("rr1_third", served[2], 2);
    tick();
    bus.req_i = 3'b110;
    collect(2);
    check("rr2_first", served[0], 2);
    check("rr2_second", served[1], 1);
    check("onehot_violations", onehot_bad, 0);
    tick();

    // BUSY stuck beyond the busy timeout, then a new request is held off until BUSY drops
    eng_delay = 0;
    eng_len   = 400;
    run_txn(2, 3'b001, 11'd9, g, dn, er, go_cyc, done_lat);
    check("busy_to_done", dn, 3'b100);
    check("busy_to_err", er, 3'b100);
    check("busy_to_latency", done_lat, 303);
    check("busy_to_hang", bus.hang_o, 1);
    check("busy_still_high", bus.BUSY, 1);
    eng_len = 2;
    set_req(1, 3'b001, 11'd3);
    holdoff_then_grant(1);
    wait_done(1, 1'b0);
    check("hang_sticky", bus.hang_o, 1);

    // Reset in the middle of WAIT_DONE with the engine still busy
    eng_len = 200;
    set_req(1, 3'b010, 11'd7);
    k = 0;
    while (!(bus.BUSY && !bus.GO && bus.gnt_o == 3'b010) && k < 50) begin
      tick();
      k++;
    end
    check("reached_wait_done", 32'(k < 50), 1);
    force_busy = 1'b1;
    eng_force  = 1'b1;
    rst        = 1'b1;
    tick();
    check("midrst_gnt", bus.gnt_o, 0);
    check("midrst_cmd_page", {bus.cmd, bus.ufm_page}, 0);
    check("midrst_go", bus.GO, 0);
    check("midrst_done_err", {bus.done_o, bus.err_o}, 0);
    check("midrst_arb_busy", bus.arb_busy_o, 0);
    check("midrst_hang", bus.hang_o, 0);
    rst    = 1'b0;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.gnt_o != 3'b000 || bus.arb_busy_o) grants++;
    end
    check("midrst_held_off", grants, 0);
    force_busy = 1'b0;
    holdoff_then_grant(1);
    eng_force = 1'b0;
    eng_len   = 2;
    wait_done(1, 1'b0);

    // GO never acknowledged
    eng_mute = 1'b1;
    run_txn(1, 3'b010, 11'd10, g, dn, er, go_cyc, done_lat);
    check("ack_to_done", dn, 3'b010);
    check("ack_to_err", er, 3'b010);
    check("ack_to_go_cycles", go_cyc, 64);
    check("ack_to_latency", done_lat, 66);
    repeat (5) tick();
    check("ack_to_hang_sticky", bus.hang_o, 1);
    eng_mute = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ufm_cmd_arbiter.md
Name: ufm_cmd_arbiter

Overview:
- Sequences the UFM command interface (cmd/ufm_page/GO/BUSY/ERR) of the UFM Wishbone top.
- Shares that interface between three requesters: req0 = erase path (enter_earse_i handler), req1 = event-save writer, req2 = BMC-side page reader.
- Grants one requester at a time, drives GO, and tracks the command through BUSY.
- Returns per-requester done/err pulses and guards against a hung flash engine with timeouts.

Parameters:
- PAGE_MAX, 11'd2046, highest legal page for read/write commands.
- ACK_TO, 64, cycles allowed from GO assertion to BUSY rising.
- TIMEOUT_CYC, 2418000, cycles allowed with BUSY high (100 ms at 24.18 MHz); counter width is 22 bits.

Ports:
- clk_i  in  1  system clock (wOSC domain)
- reset_i  in  1  synchronous, active-high reset
- req_i  in  3  level request, bit n = requester n
- req_cmd_i  in  9  cmd for requester n at bits [3n+2:3n]
- req_page_i  in  33  page for requester n at bits [11n+10:11n]
- gnt_o  out  3  one-hot grant; the granted requester owns the DPRAM port while its bit is high
- done_o  out  3  1-cycle completion pulse per requester
- err_o  out  3  1-cycle error flag, coincident with done_o
- cmd  out  3  to UFM engine
- ufm_page  out  11  to UFM engine
- GO  out  1  command strobe
- BUSY  in  1  engine busy
- ERR  in  1  engine error, valid when BUSY falls
- arb_busy_o  out  1  arbiter not in IDLE
- hang_o  out  1  sticky: a timeout occurred; cleared only by reset

Behaviour:
- Reset values: all outputs 0, except ufm_page = 0 and cmd = 3'b000.
- Legal cmd values: 3'b001 read page, 3'b010 write page, 3'b011 erase UFM. Any other value is rejected.
- States:
  - IDLE: arb_busy_o = 0. Arbitrates only when BUSY = 0. This covers a reset taken mid-operation: no grant is issued until the engine drains.
  - ARB (1 cycle): select the winner. req0 has fixed top priority. req1 and req2 alternate round-robin on a last-served bit (reset value = 1, so req1 wins first tie). Latch the winner's cmd/page and raise gnt_o.
  - CHECK (1 cycle): reject if cmd is illegal, or if cmd is read/write with page > PAGE_MAX. Rejection goes to COMPLETE with err, no GO. Otherwise go to ISSUE.
  - ISSUE: hold GO = 1 with cmd/ufm_page stable. Leave on BUSY = 1 (GO drops the same cycle, go to WAIT_DONE). If ACK_TO cycles elapse without BUSY: err, hang_o = 1, go to COMPLETE.
  - WAIT_DONE: on BUSY 1→0, err = ERR sampled that cycle, go to COMPLETE. If BUSY stays high for TIMEOUT_CYC cycles: err = 1, hang_o = 1, go to COMPLETE. The stuck engine is then held off by the IDLE BUSY check.
  - COMPLETE (1 cycle): pulse done_o[n] and err_o[n]; gnt_o drops the next cycle; update the last-served bit; go to IDLE.
- cmd/ufm_page hold their latched values through COMPLETE, then return to 0.
- A requester must drop req_i by the cycle after done_o. A req_i still high in IDLE is treated as a new request.
- A requester dropping req_i while granted does not abort the command; done_o still pulses.
- Requests arriving during a busy cycle wait; requests are never lost while held.
- gnt_o, GO and done_o are never asserted for more than one requester.
- Grant latency: a request seen in IDLE produces gnt_o 1 cycle later (ARB registered) and GO 2 cycles later.
- Timeout counter resets on every state entry. ACK_TO and TIMEOUT_CYC are exact counts.

Test Plan:
- req1 write, page 5. Engine raises BUSY 3 cycles after GO and holds it for 100 cycles with ERR = 0 → gnt_o = 3'b010; GO high exactly until BUSY rises; ufm_page = 5, cmd = 010; done_o[1] pulses once; err_o = 0.
- req0 erase, req1 and req2 asserted in the same cycle → served order 0, 1, 2; then with req1 and req2 re-asserted → order 2, 1 (round-robin).
- req2 read, page 2047 → no GO; done_o[2] = err_o[2] = 1 two cycles after grant.
- req1 with cmd = 3'b111 → same rejection, no GO.
- GO issued, BUSY never rises → err_o pulses after 64 cycles; hang_o = 1 and stays 1.
- reset_i asserted mid-WAIT_DONE with BUSY still high, req1 held → all outputs 0; no grant until BUSY falls; then the grant appears 1 cycle later.
